aes_core_arbiter: RTL
=====================

// Module: aes_core_arbiter
// PURPOSE
//  Shares one aes_top core between NUM_REQ requesters (mode modules or controller channels).
//  Arbitrates round-robin, sequences each op as cipher, decipher or key expansion, and routes
//  the result back to its requester. Tracks which requester owns the expanded key schedule.
//  Sits between the mode modules and aes_top, replacing the static flag-based mux.
// PARAMETERS
//  NUM_REQ  2    number of requesters, 1..8
//  BLK_W    128  AES block width (`BLK_S)
//  KEY_W    256  AES key width (`KEY_S); a 128-bit key occupies the upper half
// PORTS
//  clk               in   1            clock
//  reset             in   1            synchronous, active-high
//  req_valid         in   NUM_REQ      request pending, per requester
//  req_ready         out  NUM_REQ      one-hot; accept = req_valid[i] & req_ready[i]
//  req_op            in   2*NUM_REQ    per requester: 00 cipher, 01 decipher, 10 key expansion, 11 reserved
//  req_key256        in   NUM_REQ      key size for key expansion (1 = AES-256)
//  req_key_release   in   NUM_REQ      pulse: owner gives up the key schedule
//  req_blk           in   NUM_REQ*BLK_W input block, packed, requester 0 in the LSBs
//  req_key           in   NUM_REQ*KEY_W key, packed
//  rsp_valid         out  NUM_REQ      one-hot, one-cycle pulse: result for requester i
//  rsp_blk           out  BLK_W        result block, valid with rsp_valid
//  core_en_cipher    out  1            aes_top en_cipher
//  core_en_decipher  out  1            aes_top en_decipher
//  core_en_key       out  1            aes_top en_key
//  core_aes128_mode  out  1            aes_top mode select
//  core_aes256_mode  out  1            aes_top mode select
//  core_key          out  KEY_W        aes_top key
//  core_in_blk       out  BLK_W        aes_top input block
//  core_out_blk      in   BLK_W        aes_top output block
//  core_done         in   1            aes_top en_o
//  core_busy         in   1            aes_top aes_op_in_progress
//  arb_busy          out  1            FSM not in IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, FSM IDLE, rr_ptr = NUM_REQ-1, key_valid = 0, key_owner = 0.
//  Eligibility of requester i:
//    - op 10: eligible when !key_valid or key_owner == i.
//    - op 00/01: eligible only when key_valid and key_owner == i.
//    - op 11: never eligible and never accepted.
//  FSM states:
//    - IDLE: pick the first eligible i after rr_ptr (wrap mod NUM_REQ). Assert req_ready[i]
//      combinationally, capture op, blk and key, set grant = i, go to ISSUE.
//    - ISSUE: wait while core_busy. Otherwise pulse exactly one core_en_* for 1 cycle, go to WAIT.
//    - WAIT: on core_done, register core_out_blk into rsp_blk, pulse rsp_valid[grant],
//      set rr_ptr = grant, go to IDLE.
//  Key expansion: on core_done set key_valid = 1, key_owner = grant, and latch key256.
//    rsp_valid still pulses, with rsp_blk = 0.
//  Core mode lines: core_aes256_mode = the latched key256 (request key256 during expansion),
//    core_aes128_mode = its inverse. Cipher/decipher ignore req_key256.
//  Drive: core_key and core_in_blk come from the capture registers, held stable ISSUE through WAIT.
//  Latency: accept at T, core_en_* at T+1 (core idle), rsp_valid at T+2+L, L = core latency.
//    Next accept no earlier than the cycle after rsp_valid.
//  Release:
//    - req_key_release[key_owner] clears key_valid at the next edge. Eligibility uses the
//      registered key_valid, so a release and a request on the same cycle take effect next cycle.
//    - A release from a non-owner is ignored.
//    - A release during WAIT of a key op by that owner is applied after its completion.
//  Spurious inputs: core_done outside WAIT is ignored. req_valid deasserted before accept is legal.
//  Reset mid-op: FSM returns to IDLE, no rsp_valid is issued, and key_valid clears.
// STRUCTURE
//  Op encodings (AES_OP_CIPHER, AES_OP_DECIPHER, AES_OP_KEYEXP) are added to aes.vh for the mode modules.
//  Sub-module rr_arbiter #(N): eligible mask + rr_ptr -> one-hot grant and index, combinational.
//  Top level holds the FSM, capture registers and key-ownership state.
// TESTING
//  1. R0 key expansion, AES-128 key 000102..0f -> rsp_valid=01, key_owner=0, core_en_key pulses once.
//  2. R0 cipher on 00112233445566778899aabbccddeeff -> rsp_blk=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_valid=01.
//  3. R1 requests key expansion while R0 owns the key -> no accept. After R0 release, R1 is
//     accepted and key_owner=1.
//  4. R0 and R1 both eligible (NUM_REQ=2, each owning by turn, key ops) -> grants alternate 0,1,0,1.
//     No rsp_valid ever has two bits set.
//  5. R1 cipher with key_valid=0 -> never accepted. Reserved op 11 -> never accepted.
//  6. Reset asserted in WAIT -> no rsp_valid, arb_busy=0 and key_valid=0 the cycle after reset.

Source files
------------

// File: rtl/aes_core_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_core_arbiter_pkg
//  Description : Shared types for the AES core arbiter. This file holds the
//                op encodings used by the requesters and the arbiter FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_core_arbiter_pkg;

    // Requester op field encoding. These values match the codes the mode
    // modules drive.
    typedef enum logic [1:0] {
        AES_OP_CIPHER   = 2'b00,
        AES_OP_DECIPHER = 2'b01,
        AES_OP_KEYEXP   = 2'b10,
        AES_OP_RSVD     = 2'b11
    } aes_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_core_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. It returns the first
//                eligible requester after rr_ptr, wrapping modulo N.
//  Ports       : eligible    - per-requester eligibility mask
//                rr_ptr      - last granted index
//                grant_oh    - one-hot grant (zero when nothing eligible)
//                grant_idx   - binary index of the grant
//                grant_valid - any requester selected
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);
    localparam int DW = IDX_W + 1;

    logic [DW-1:0] w_dist;
    logic [DW-1:0] w_best;

    // Each candidate gets a distance measured from the slot after rr_ptr.
    // The candidate with the smallest distance wins. The loop index is used
    // only as a constant select.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_best      = '1;
        w_dist      = '0;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) > rr_ptr) begin
                w_dist = DW'(i) - {1'b0, rr_ptr} - DW'(1);
            end else begin
                w_dist = DW'(i) + DW'(N) - {1'b0, rr_ptr} - DW'(1);
            end
            if (eligible[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = IDX_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_core_arbiter
//  Description : Shares one aes_top core between NUM_REQ requesters. It picks
//                requesters round-robin, issues cipher, decipher or key
//                expansion ops, and routes each result back to its requester.
//                It also records which requester owns the expanded key
//                schedule.
//  Ports       : req_*   - per-requester handshake, op, key and block (packed,
//                          requester 0 in the LSBs)
//                rsp_*   - one-hot result pulse and the shared result block
//                core_*  - aes_top control, data and status
//                arb_busy- an op is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_core_arbiter
    import aes_core_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int BLK_W   = 128,
    parameter int KEY_W   = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [NUM_REQ-1:0]       req_key256,
    input  logic [NUM_REQ-1:0]       req_key_release,
    input  logic [NUM_REQ*BLK_W-1:0] req_blk,
    input  logic [NUM_REQ*KEY_W-1:0] req_key,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [BLK_W-1:0]         rsp_blk,
    output logic                     core_en_cipher,
    output logic                     core_en_decipher,
    output logic                     core_en_key,
    output logic                     core_aes128_mode,
    output logic                     core_aes256_mode,
    output logic [KEY_W-1:0]         core_key,
    output logic [BLK_W-1:0]         core_in_blk,
    input  logic [BLK_W-1:0]         core_out_blk,
    input  logic                     core_done,
    input  logic                     core_busy,
    output logic                     arb_busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q, state_d;
    aes_op_e            op_q, op_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   key_owner_q, key_owner_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   rsp_blk_q, rsp_blk_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               exp256_q, exp256_d;      // key size of the expansion in flight
    logic               key256_q, key256_d;      // key size of the installed schedule
    logic               key_valid_q, key_valid_d;
    logic               rel_pend_q, rel_pend_d;  // owner released during its own re-expansion

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [NUM_REQ-1:0] w_grant_q_oh;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_grant_valid;
    logic               w_accept;
    logic               w_rel_hit;
    logic               w_hold_release;
    aes_op_e            w_sel_op;
    logic [BLK_W-1:0]   w_sel_blk;
    logic [KEY_W-1:0]   w_sel_key;
    logic               w_sel_256;
    logic               w_mode256;
    logic               w_mode_act;

    // Eligibility is based on the registered key state. A release and a
    // request in the same cycle therefore take effect one cycle later.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        aes_op_e w_op;
        logic    w_owns;
        assign w_op   = aes_op_e'(req_op[2*gi +: 2]);
        assign w_owns = key_valid_q && (key_owner_q == IDX_W'(gi));
        assign w_eligible[gi] = req_valid[gi] &&
            (((w_op == AES_OP_KEYEXP) && (!key_valid_q || w_owns)) ||
             (((w_op == AES_OP_CIPHER) || (w_op == AES_OP_DECIPHER)) && w_owns));
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .eligible    (w_eligible),
        .rr_ptr      (rr_ptr_q),
        .grant_oh    (w_grant_oh),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    // Field muxes: the winning requester's fields, the release from the
    // current owner, and the one-hot form of the latched grant.
    always_comb begin
        w_sel_op     = AES_OP_CIPHER;
        w_sel_blk    = '0;
        w_sel_key    = '0;
        w_sel_256    = 1'b0;
        w_rel_hit    = 1'b0;
        w_grant_q_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == IDX_W'(i)) begin
                w_sel_op  = aes_op_e'(req_op[2*i +: 2]);
                w_sel_blk = req_blk[i*BLK_W +: BLK_W];
                w_sel_key = req_key[i*KEY_W +: KEY_W];
                w_sel_256 = req_key256[i];
            end
            if (key_owner_q == IDX_W'(i)) begin
                w_rel_hit = key_valid_q && req_key_release[i];
            end
            if (grant_q == IDX_W'(i)) begin
                w_grant_q_oh[i] = 1'b1;
            end
        end
    end

    // A new accept cannot happen in the cycle that the previous result is
    // presented.
    assign w_accept  = !reset && (state_q == ST_IDLE) && (rsp_valid_q == '0) && w_grant_valid;
    assign req_ready = w_accept ? w_grant_oh : '0;

    // If the owner releases while its own key expansion is in progress, the
    // release must not act on the schedule that is being rebuilt. It is held
    // in rel_pend and applied when that expansion completes.
    assign w_hold_release = (state_q == ST_WAIT) && (op_q == AES_OP_KEYEXP) && (grant_q == key_owner_q);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        key_owner_d = key_owner_q;
        blk_d       = blk_q;
        key_d       = key_q;
        exp256_d    = exp256_q;
        key256_d    = key256_q;
        key_valid_d = key_valid_q;
        rel_pend_d  = rel_pend_q;
        rsp_blk_d   = rsp_blk_q;
        rsp_valid_d = '0;

        if (w_rel_hit) begin
            if (w_hold_release) begin
                rel_pend_d = 1'b1;
            end else begin
                key_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    op_d     = w_sel_op;
                    blk_d    = w_sel_blk;
                    key_d    = w_sel_key;
                    exp256_d = w_sel_256;
                    grant_d  = w_grant_idx;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!core_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    rsp_valid_d = w_grant_q_oh;
                    rr_ptr_d    = grant_q;
                    state_d     = ST_IDLE;
                    if (op_q == AES_OP_KEYEXP) begin
                        rsp_blk_d   = '0;
                        key_valid_d = !(rel_pend_q || w_rel_hit);
                        key_owner_d = grant_q;
                        key256_d    = exp256_q;
                        rel_pend_d  = 1'b0;
                    end else begin
                        rsp_blk_d = core_out_blk;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= AES_OP_CIPHER;
            grant_q     <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            key_owner_q <= '0;
            blk_q       <= '0;
            key_q       <= '0;
            exp256_q    <= 1'b0;
            key256_q    <= 1'b0;
            key_valid_q <= 1'b0;
            rel_pend_q  <= 1'b0;
            rsp_blk_q   <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            key_owner_q <= key_owner_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            exp256_q    <= exp256_d;
            key256_q    <= key256_d;
            key_valid_q <= key_valid_d;
            rel_pend_q  <= rel_pend_d;
            rsp_blk_q   <= rsp_blk_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // The enable is a single-cycle pulse. It is decoded from the ISSUE state,
    // so it appears in the cycle after accept whenever the core is idle.
    assign core_en_cipher   = (state_q == ST_ISSUE) && !core_busy && (op_q == AES_OP_CIPHER);
    assign core_en_decipher = (state_q == ST_ISSUE) && !core_busy && (op_q == AES_OP_DECIPHER);
    assign core_en_key      = (state_q == ST_ISSUE) && !core_busy && (op_q == AES_OP_KEYEXP);

    // During an expansion the mode lines follow the requested key size.
    // At all other times they follow the installed schedule. Both lines stay
    // low when there is nothing to describe.
    assign w_mode256        = ((state_q != ST_IDLE) && (op_q == AES_OP_KEYEXP)) ? exp256_q : key256_q;
    assign w_mode_act       = key_valid_q || (state_q != ST_IDLE);
    assign core_aes256_mode = w_mode_act && w_mode256;
    assign core_aes128_mode = w_mode_act && !w_mode256;

    assign core_key    = key_q;
    assign core_in_blk = blk_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_blk     = rsp_blk_q;
    assign arb_busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire
